fp24_inv_arbiter: RTL
=====================

// Module: fp24_inv_arbiter
// PURPOSE
// - Shares one fp24_inv pipeline (latency INV_DELAY cycles, no valid/stall) among N_REQ requesters.
// - Round-robin admits at most one operand per cycle and tracks requester id + valid alongside the datapath.
// - Buffers results in an output FIFO with valid/ready; credit accounting means a result is never dropped.
// - Typical clients: per-pixel/per-ray normalisation units needing 1/x.
// PARAMETERS
// - N_REQ       4   number of requesters (>=2)
// - FIFO_DEPTH  16  result FIFO entries; must be >= INV_DELAY+1 for full throughput
// - ID_W        $clog2(N_REQ)  width of requester id (derived, localparam)
// PORTS
// - clk           in   1            clock, rising edge
// - rst           in   1            asynchronous reset, active-low (asserted when 0)
// - req_valid     in   N_REQ        requester i has operand pending
// - req_x         in   N_REQ x 24   fp24 operand per requester
// - req_ready     out  N_REQ        one-hot grant; transfer when req_valid[i] & req_ready[i]
// - resp_valid    out  1            result FIFO head valid
// - resp_id       out  ID_W         requester that issued the head result
// - resp_x_inv    out  24           fp24 1/x for the head result
// - resp_ready    in   1            consumer accepts head; pop when resp_valid & resp_ready
// - busy          out  1            any op in flight or any FIFO entry occupied
// BEHAVIOUR
// - Reset (rst=0, async): rr pointer=0, tag-pipe valids=0, FIFO empty, credits=FIFO_DEPTH.
//   Outputs during/after reset: req_ready=0, resp_valid=0, resp_id=0, resp_x_inv=0, busy=0.
// - Credit: credits = FIFO_DEPTH - (in-flight + FIFO occupancy).
//   Issue allowed only if credits>0, or credits==0 with a pop in the same cycle.
// - Arbitration (combinational on req_valid, pointer, credit):
//   - grant lowest i >= ptr (wrapping) with req_valid[i]; req_ready is that one-hot, 0 if no credit.
//   - req_ready[i] never asserts without req_valid[i].
//   - On issue, ptr <= grant+1 mod N_REQ; ptr holds when idle.
// - Issue cycle t: fp24_inv.x <= req_x[grant]; tag {1, grant} enters INV_DELAY-deep shift register.
//   - Non-issue cycles drive x=0 and shift in tag valid=0. Datapath never stalls.
// - Cycle t+INV_DELAY: tag valid -> push {id, x_inv} into FIFO.
//   - Credit rule guarantees no overflow; an overflow is an assertion failure.
// - Simultaneous push+pop on full/empty FIFO both legal.
//   - Empty: push+pop -> stays empty; written data appears next cycle, no bypass.
//   - Count and credits are updated net of push, pop and issue in the same cycle.
// - Latency: issue -> resp_valid at earliest INV_DELAY+1 cycles (FIFO registered). Throughput 1 op/cycle.
// - Ordering: results leave in issue order globally, hence per requester too.
// - Reset mid-operation: all in-flight tags and FIFO contents discarded.
//   - fp24_inv internal regs are unreset; their garbage is ignored since tag valids are 0.
// - Numerics belong to fp24_inv: zero/inf/denormal inputs produce unspecified values, but id/valid still correct.
// - busy = |tag_valid | (fifo_count!=0).
// STRUCTURE
// - Shared package: fp24 typedef, INV_DELAY, fields sign[23]/exp[22:16]/mant[15:0]; new typedef inv_tag_t {valid, id}.
// - Sub-module rr_arbiter #(N) (req, ptr -> one-hot grant); reusable for other shared units.
// - In-file: tag shift register (pipeline primitive, WIDTH=1+ID_W, DEPTH=INV_DELAY, valid bits async-cleared), FIFO, credit counter.
// - Instantiates one fp24_inv; its rst port tied to ~rst (unused internally).
// TESTING
// - Single op: req 0 issues x=0x400000 (2.0) -> resp_id=0, resp_x_inv~0x3E0000 (0.5, <=2 ulp) at INV_DELAY+1 cycles.
// - Fairness: all 4 req_valid held high 16 cycles -> grants 0,1,2,3,0,... each id 4 results, issue order preserved.
// - Backpressure: resp_ready=0 with continuous requests -> exactly FIFO_DEPTH issues, req_ready=0 after.
//   - Then resp_ready=1 -> all 16 drain, no loss/duplication.
// - Full+pop: FIFO full, resp_ready=1 and req_valid=1 same cycle -> issue occurs that cycle, count stays bounded.
// - Async reset mid-flight: 5 ops issued, rst=0 for 1 cycle at t+3 -> resp_valid=0, busy=0.
//   - No stale results for 2*INV_DELAY cycles.
// - Mixed values: req1 x=0x410000 (4.0), req2 x=0xBD0000 (-0.25) back-to-back.
//   - -> (1, ~0x3D0000) then (2, ~0xC10000).

Source files
------------

// File: rtl/fp24_inv_arbiter_pkg.sv
// Shared fp24 types and pipeline constants for the shared reciprocal unit.
// fp24 layout: sign[23], biased exponent[22:16] (bias 63), fraction[15:0] with hidden 1.
package fp24_inv_arbiter_pkg;

  localparam int INV_DELAY = 4;
  localparam int MAX_ID_W  = 8;
  localparam int EXP_BIAS  = 63;

  typedef struct packed {
    logic        sign;
    logic [6:0]  exp;
    logic [15:0] mant;
  } fp24_t;

  // Sideband carried alongside the datapath; id is sized for the largest supported requester count.
  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } inv_tag_t;

endpackage

// File: rtl/fp24_inv.sv
// Fixed-latency fp24 reciprocal: INV_DELAY register stages, no reset, no stall.
// Zero/inf/denormal inputs yield unspecified values.
module fp24_inv
  import fp24_inv_arbiter_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  fp24_t x,
  output fp24_t x_inv
);

  fp24_t       x_q;
  fp24_t       recip;
  fp24_t       pipe [INV_DELAY-1];
  logic [17:0] q;
  logic        unused_rst;

  assign unused_rst = rst;

  // q = 2^33 / 1.m lies in (2^16, 2^17]; only 1.0 exactly reaches 2^17.
  always_comb begin
    q     = 18'(34'h2_0000_0000 / {17'd0, 1'b1, x_q.mant});
    recip = '0;
    recip.sign = x_q.sign;
    if (q[17]) begin
      recip.exp  = 7'(2 * EXP_BIAS) - x_q.exp;
      recip.mant = q[16:1];
    end else begin
      recip.exp  = 7'(2 * EXP_BIAS - 1) - x_q.exp;
      recip.mant = q[15:0];
    end
  end

  // NOTE: datapath registers carry no reset; validity travels in the caller's tag pipe.
  always_ff @(posedge clk) begin
    x_q     <= x;
    pipe[0] <= recip;
    for (int i = 1; i < INV_DELAY - 1; i++) pipe[i] <= pipe[i-1];
  end

  assign x_inv = pipe[INV_DELAY-2];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: lowest requesting index at or after ptr, wrapping.
// Purely combinational so it can front any shared unit.
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_id,
  output logic         any
);

  int          sum;
  logic [W-1:0] idx;

  // NOTE: every output gets a default before the loop, so no path leaves a value held (no latch).
  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    sum      = 0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      sum = int'(ptr) + k;
      if (sum >= N) sum = sum - N;
      idx = W'(sum);
      if (!any && req[idx]) begin
        any         = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

endmodule

// File: rtl/fp24_inv_arbiter.sv
// Shares one fp24_inv among N_REQ requesters: round-robin issue, tag pipe, result FIFO.
// Credits reserve a FIFO slot at issue time so no result is ever dropped.
module fp24_inv_arbiter
  import fp24_inv_arbiter_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0][23:0]   req_x,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     resp_valid,
  output logic [$clog2(N_REQ)-1:0] resp_id,
  output logic [23:0]              resp_x_inv,
  input  logic                     resp_ready,
  output logic                     busy
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  grant_id;
  logic [N_REQ-1:0] grant;
  logic             any_req;
  logic             issue;
  logic             push;
  logic             pop;
  logic             has_credit;
  logic             inflight;
  logic [CNT_W-1:0] credits;
  logic [CNT_W-1:0] fifo_count;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  fp24_t            inv_x;
  fp24_t            inv_y;
  inv_tag_t         tag_sr [INV_DELAY];
  inv_tag_t         tag_in;
  inv_tag_t         tag_out;
  logic [ID_W-1:0]  mem_id [FIFO_DEPTH];
  fp24_t            mem_x  [FIFO_DEPTH];
  logic [MAX_ID_W-1:0] unused_tag_id;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req      (req_valid),
    .ptr      (ptr),
    .grant    (grant),
    .grant_id (grant_id),
    .any      (any_req)
  );

  // A pop in the same cycle frees the slot the new issue will eventually need.
  assign pop        = resp_valid & resp_ready;
  assign has_credit = (credits != '0) | pop;
  assign issue      = rst & any_req & has_credit;
  assign req_ready  = issue ? grant : '0;
  assign inv_x      = issue ? fp24_t'(req_x[grant_id]) : '0;

  fp24_inv u_inv (
    .clk   (clk),
    .rst   (~rst),
    .x     (inv_x),
    .x_inv (inv_y)
  );

  assign tag_in  = '{valid: issue, id: MAX_ID_W'(grant_id)};
  assign tag_out = tag_sr[INV_DELAY-1];
  assign push    = tag_out.valid;
  assign unused_tag_id = tag_out.id;

  // NOTE: non-blocking assignments make every register sample pre-edge values, so the shift is order-independent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < INV_DELAY; i++) tag_sr[i] <= '0;
    end else begin
      tag_sr[0] <= tag_in;
      for (int i = 1; i < INV_DELAY; i++) tag_sr[i] <= tag_sr[i-1];
    end
  end

  always_comb begin
    inflight = 1'b0;
    for (int i = 0; i < INV_DELAY; i++) inflight = inflight | tag_sr[i].valid;
  end

  // NOTE: FIFO storage is not reset; fifo_count gates every read, so stale words never escape.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_id[wr_ptr] <= tag_out.id[ID_W-1:0];
      mem_x[wr_ptr]  <= inv_y;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      credits    <= CNT_W'(FIFO_DEPTH);
    end else begin
      if (issue) ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
      if (push)  wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)   rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      credits    <= credits - CNT_W'(issue) + CNT_W'(pop);
    end
  end

  assign resp_valid = (fifo_count != '0);
  assign resp_id    = resp_valid ? mem_id[rd_ptr] : '0;
  assign resp_x_inv = resp_valid ? mem_x[rd_ptr] : '0;
  assign busy       = inflight | resp_valid;

  no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && fifo_count == CNT_W'(FIFO_DEPTH)));

endmodule
